// File: rtl/gardner_ted_v2_if.sv
// Sample/strobe inputs and error/raw outputs of the Gardner timing-error detector.
`timescale 1ns/1ps
interface gardner_ted_v2_if #(
  parameter int WI = 16,
  parameter int WO = 18
);
  logic signed [WI-1:0] i_in;
  logic signed [WI-1:0] q_in;
  logic                 iq_val;
  logic                 sym_valid_i;
  logic                 q_en_i;
  logic                 flush_i;
  logic signed [WO-1:0] e_out_o;
  logic                 e_valid_o;
  logic                 e_sat_o;
  logic                 ready_o;
  logic [WI-1:0]        i_raw_delay_o;
  logic [WI-1:0]        q_raw_delay_o;

  modport master (
    output i_in, q_in, iq_val, sym_valid_i, q_en_i, flush_i,
    input  e_out_o, e_valid_o, e_sat_o, ready_o, i_raw_delay_o, q_raw_delay_o
  );

  modport slave (
    input  i_in, q_in, iq_val, sym_valid_i, q_en_i, flush_i,
    output e_out_o, e_valid_o, e_sat_o, ready_o, i_raw_delay_o, q_raw_delay_o
  );
endinterface

// File: rtl/gardner_ted_v2.sv
// Gardner timing-error detector: Ih*(Ic-Ip) [+ Qh*(Qc-Qp)], shifted, saturated,
// sampled on symbol strobes and delivered through a PIPE_LAT-deep pipeline.
`timescale 1ns/1ps
module gardner_ted_v2 #(
  parameter int OSF      = 20,
  parameter int WI       = 16,
  parameter int WO       = 18,
  parameter int SHIFT_R  = 16,
  parameter int PIPE_LAT = 4,
  parameter int RAW_DLY  = 20
) (
  input  logic             clk,
  input  logic             reset_n,
  gardner_ted_v2_if.slave  bus
);

  localparam int D  = (OSF > RAW_DLY + PIPE_LAT + 1) ? OSF : RAW_DLY + PIPE_LAT + 1;
  localparam int PW = 2 * WI + 2;
  localparam int CW = $clog2(OSF + 1);
  localparam logic signed [PW-1:0] EMAX = {{(PW-WO+1){1'b0}}, {(WO-1){1'b1}}};
  localparam logic signed [PW-1:0] EMIN = ~EMAX;

  logic signed [WI-1:0] line_i [D];
  logic signed [WI-1:0] line_q [D];
  logic [CW-1:0]        fill_cnt;
  logic                 ready;

  logic signed [WO-1:0] pipe_e   [PIPE_LAT];
  logic                 pipe_sat [PIPE_LAT];
  logic                 pipe_vld [PIPE_LAT];

  logic signed [WI:0]   diff_i;
  logic signed [WI:0]   diff_q;
  logic signed [PW-1:0] prod_i;
  logic signed [PW-1:0] prod_q;
  logic signed [PW-1:0] prod_sum;
  logic signed [PW-1:0] prod_shr;
  logic signed [WO-1:0] err_val;
  logic                 err_clip;
  logic                 take;

  assign ready = (fill_cnt == CW'(OSF));
  assign take  = bus.sym_valid_i & bus.iq_val & ready;

  // Full-precision error: operands are sign-extended to PW bits so neither arm can overflow.
  always_comb begin
    diff_i   = {bus.i_in[WI-1], bus.i_in} - {line_i[OSF-1][WI-1], line_i[OSF-1]};
    diff_q   = {bus.q_in[WI-1], bus.q_in} - {line_q[OSF-1][WI-1], line_q[OSF-1]};
    prod_i   = PW'(line_i[OSF/2-1]) * PW'(diff_i);
    prod_q   = bus.q_en_i ? PW'(line_q[OSF/2-1]) * PW'(diff_q) : '0;
    prod_sum = prod_i + prod_q;
    prod_shr = prod_sum >>> SHIFT_R;
    err_clip = 1'b0;
    err_val  = prod_shr[WO-1:0];
    if (prod_shr > EMAX) begin
      err_val  = EMAX[WO-1:0];
      err_clip = 1'b1;
    end else if (prod_shr < EMIN) begin
      err_val  = EMIN[WO-1:0];
      err_clip = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < D; k++) begin
        line_i[k] <= '0;
        line_q[k] <= '0;
      end
      fill_cnt <= '0;
    end else if (bus.flush_i) begin
      for (int k = 0; k < D; k++) begin
        line_i[k] <= '0;
        line_q[k] <= '0;
      end
      fill_cnt <= '0;
    end else if (bus.iq_val) begin
      line_i[0] <= bus.i_in;
      line_q[0] <= bus.q_in;
      for (int k = 1; k < D; k++) begin
        line_i[k] <= line_i[k-1];
        line_q[k] <= line_q[k-1];
      end
      if (!ready) fill_cnt <= fill_cnt + CW'(1);
    end
  end

  // Data stages load only behind a valid, so the last stage holds the newest error between strobes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < PIPE_LAT; k++) begin
        pipe_e[k]   <= '0;
        pipe_sat[k] <= 1'b0;
        pipe_vld[k] <= 1'b0;
      end
    end else if (bus.flush_i) begin
      for (int k = 0; k < PIPE_LAT; k++) pipe_vld[k] <= 1'b0;
    end else begin
      pipe_vld[0] <= take;
      if (take) begin
        pipe_e[0]   <= err_val;
        pipe_sat[0] <= err_clip;
      end
      for (int k = 1; k < PIPE_LAT; k++) begin
        pipe_vld[k] <= pipe_vld[k-1];
        if (pipe_vld[k-1]) begin
          pipe_e[k]   <= pipe_e[k-1];
          pipe_sat[k] <= pipe_sat[k-1];
        end
      end
    end
  end

  assign bus.e_out_o       = pipe_e[PIPE_LAT-1];
  assign bus.e_sat_o       = pipe_sat[PIPE_LAT-1];
  assign bus.e_valid_o     = pipe_vld[PIPE_LAT-1];
  assign bus.ready_o       = ready;
  assign bus.i_raw_delay_o = line_i[RAW_DLY+PIPE_LAT];
  assign bus.q_raw_delay_o = line_q[RAW_DLY+PIPE_LAT];

endmodule

// File: tb/tb_gardner_ted_v2.sv
// Bench for gardner_ted_v2: two configurations driven in parallel, each with its own
// sample-history model and expected-error queue drained by a monitor.
`timescale 1ns/1ps
module tb_gardner_ted_v2;

  localparam int OSF = 20;
  localparam int WI  = 16;
  localparam int WO  = 18;
  localparam int PL  = 4;
  localparam longint EMAX = (longint'(1) << (WO - 1)) - 1;
  localparam longint EMIN = -EMAX - 1;

  typedef struct {
    longint due;
    longint val;
    bit     sat;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic signed [WI-1:0] i_in = '0;
  logic signed [WI-1:0] q_in = '0;
  logic                 iq_val = 1'b0;
  logic                 sym_valid = 1'b0;
  logic                 q_en = 1'b0;
  logic                 flush = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  function automatic longint edge_idx();
    return (longint'($time) - 5) / 10;
  endfunction

  function automatic longint tap(input longint h[$], input int k);
    if (k < h.size()) return h[k];
    return 0;
  endfunction

  function automatic longint floor_shift(input longint p, input int sr);
    longint d;
    longint q;
    d = longint'(1) << sr;
    q = p / d;
    if ((p % d) != 0 && p < 0) q = q - 1;
    return q;
  endfunction

  task automatic check_output(input string name, input longint actual, input longint expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_cfg
    localparam int SR      = (g == 0) ? 16 : 8;
    localparam int RD      = (g == 0) ? 20 : 3;
    localparam int RAW_TAP = RD + PL;

    gardner_ted_v2_if #(.WI(WI), .WO(WO)) bus ();

    assign bus.i_in        = i_in;
    assign bus.q_in        = q_in;
    assign bus.iq_val      = iq_val;
    assign bus.sym_valid_i = sym_valid;
    assign bus.q_en_i      = q_en;
    assign bus.flush_i     = flush;

    gardner_ted_v2 #(
      .OSF(OSF), .WI(WI), .WO(WO), .SHIFT_R(SR), .PIPE_LAT(PL), .RAW_DLY(RD)
    ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .bus(bus.slave)
    );

    exp_t   exp_q[$];
    longint hi[$];
    longint hq[$];
    int     cnt = 0;
    longint last_out = 0;
    bit     last_sat = 1'b0;
    longint p, v;
    exp_t   e, cur;
    logic [WI-1:0] raw_i, raw_q;
    longint ti, tq;

    // History of accepted samples, newest first; an error is due PL-1 edges after its strobe edge.
    always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        hi.delete();
        hq.delete();
        exp_q.delete();
        cnt = 0;
        last_out = 0;
        last_sat = 1'b0;
      end else if (flush) begin
        hi.delete();
        hq.delete();
        exp_q.delete();
        cnt = 0;
      end else if (iq_val) begin
        if (sym_valid && cnt == OSF) begin
          p = tap(hi, OSF/2 - 1) * (longint'(i_in) - tap(hi, OSF - 1));
          if (q_en) p = p + tap(hq, OSF/2 - 1) * (longint'(q_in) - tap(hq, OSF - 1));
          v = floor_shift(p, SR);
          e.sat = 1'b0;
          if (v > EMAX) begin
            v = EMAX;
            e.sat = 1'b1;
          end else if (v < EMIN) begin
            v = EMIN;
            e.sat = 1'b1;
          end
          e.val = v;
          e.due = edge_idx() + PL - 1;
          exp_q.push_back(e);
        end
        hi.push_front(longint'(i_in));
        hq.push_front(longint'(q_in));
        if (hi.size() > 64) begin
          void'(hi.pop_back());
          void'(hq.pop_back());
        end
        if (cnt < OSF) cnt++;
      end
    end

    always @(negedge clk) begin
      if (bus.e_valid_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          check_output($sformatf("cfg%0d unexpected e_valid_o", g), bus.e_valid_o, 0);
        end else begin
          cur = exp_q.pop_front();
          check_output($sformatf("cfg%0d e_valid_o edge", g), edge_idx(), cur.due);
          check_output($sformatf("cfg%0d e_out_o", g), bus.e_out_o, cur.val);
          check_output($sformatf("cfg%0d e_sat_o", g), bus.e_sat_o, cur.sat);
          last_out = cur.val;
          last_sat = cur.sat;
        end
      end else begin
        check_output($sformatf("cfg%0d e_out_o hold", g), bus.e_out_o, last_out);
        check_output($sformatf("cfg%0d e_sat_o hold", g), bus.e_sat_o, last_sat);
        while (exp_q.size() > 0 && exp_q[0].due <= edge_idx()) begin
          check_output($sformatf("cfg%0d missing e_valid_o", g), bus.e_valid_o, 1);
          void'(exp_q.pop_front());
        end
      end
      check_output($sformatf("cfg%0d ready_o", g), bus.ready_o, (cnt == OSF) ? 1 : 0);
      ti = tap(hi, RAW_TAP);
      tq = tap(hq, RAW_TAP);
      raw_i = ti[WI-1:0];
      raw_q = tq[WI-1:0];
      check_output($sformatf("cfg%0d i_raw_delay_o", g), bus.i_raw_delay_o, raw_i);
      check_output($sformatf("cfg%0d q_raw_delay_o", g), bus.q_raw_delay_o, raw_q);
    end
  end

  task automatic apply_stimulus(input bit v, input bit s, input longint i, input longint q,
                                input bit qe, input bit fl);
    i_in      = i[WI-1:0];
    q_in      = q[WI-1:0];
    iq_val    = v;
    sym_valid = s;
    q_en      = qe;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) apply_stimulus(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  // OSF samples place ip at the previous tap and ih at the half tap; the strobe carries ic.
  task automatic feed_symbol(input longint ip, input longint ih, input longint ic,
                             input longint qp, input longint qh, input longint qc, input bit qe);
    longint si, sq;
    for (int j = 1; j <= OSF; j++) begin
      si = (j == 1) ? ip : (j == OSF/2 + 1) ? ih : 0;
      sq = (j == 1) ? qp : (j == OSF/2 + 1) ? qh : 0;
      apply_stimulus(1'b1, 1'b0, si, sq, qe, 1'b0);
    end
    apply_stimulus(1'b1, 1'b1, ic, qc, qe, 1'b0);
  endtask

  initial begin
    longint sent[$];
    longint rs;

    $display("[TB] start");
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("reset ready_o", g_cfg[0].bus.ready_o, 0);
    check_output("reset e_valid_o", g_cfg[0].bus.e_valid_o, 0);
    check_output("reset e_out_o", g_cfg[0].bus.e_out_o, 0);
    check_output("reset e_sat_o", g_cfg[1].bus.e_sat_o, 0);
    @(posedge clk);
    #1 reset_n = 1'b1;

    // Strobes during fill are ignored; ready rises on the OSF-th sample.
    for (int j = 0; j < OSF - 1; j++)
      apply_stimulus(1'b1, 1'b1, $urandom, $urandom, 1'b1, 1'b0);
    @(negedge clk);
    check_output("ready_o before fill", g_cfg[0].bus.ready_o, 0);
    apply_stimulus(1'b1, 1'b1, $urandom, $urandom, 1'b1, 1'b0);
    @(negedge clk);
    check_output("ready_o at fill", g_cfg[0].bus.ready_o, 1);
    idle(PL + 2);

    // Constant input gives zero error on every strobe.
    for (int s = 0; s < 6; s++)
      for (int j = 0; j < OSF; j++)
        apply_stimulus(1'b1, (s > 0 && j == OSF - 1), 1000, 1000, 1'b1, 1'b0);
    idle(PL + 1);
    @(negedge clk);
    check_output("constant e_out_o cfg0", g_cfg[0].bus.e_out_o, 0);
    check_output("constant e_out_o cfg1", g_cfg[1].bus.e_out_o, 0);

    feed_symbol(-8192, 4096, 8192, $urandom, $urandom, $urandom, 1'b0);
    idle(2);
    @(negedge clk);
    check_output("latency early e_valid_o", g_cfg[0].bus.e_valid_o, 0);
    idle(1);
    @(negedge clk);
    check_output("latency e_valid_o", g_cfg[0].bus.e_valid_o, 1);
    check_output("I-arm e_out_o", g_cfg[0].bus.e_out_o, 1024);
    check_output("I-arm e_sat_o", g_cfg[0].bus.e_sat_o, 0);
    check_output("I-arm shift8 e_out_o", g_cfg[1].bus.e_out_o, 131071);
    check_output("I-arm shift8 e_sat_o", g_cfg[1].bus.e_sat_o, 1);

    feed_symbol(-32768, -32768, 32767, -32768, -32768, 32767, 1'b1);
    idle(PL);
    check_output("neg sat e_out_o", g_cfg[1].bus.e_out_o, -131072);
    check_output("neg sat e_sat_o", g_cfg[1].bus.e_sat_o, 1);
    check_output("neg shift16 e_out_o", g_cfg[0].bus.e_out_o, -65535);
    check_output("neg shift16 e_sat_o", g_cfg[0].bus.e_sat_o, 0);

    // Flush two cycles after a strobe: that error must never appear.
    feed_symbol($urandom, $urandom, $urandom, $urandom, $urandom, $urandom, 1'b1);
    idle(1);
    apply_stimulus(1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
    for (int j = 0; j < OSF; j++) begin
      @(negedge clk);
      check_output("ready_o after flush", g_cfg[0].bus.ready_o, 0);
      apply_stimulus(1'b1, 1'b1, $urandom, $urandom, 1'b1, 1'b0);
    end
    @(negedge clk);
    check_output("ready_o refilled", g_cfg[0].bus.ready_o, 1);

    // Alternating iq_val: raw tap of cfg1 sits RAW_DLY+PL = 7 entries back.
    for (int j = 0; j < 40; j++) begin
      rs = longint'($urandom_range(0, 65535)) - 32768;
      apply_stimulus(j[0] == 1'b0, 1'b0, rs, $urandom, 1'b0, 1'b0);
      if (j[0] == 1'b0) sent.push_back(rs);
      if (sent.size() >= 8) begin
        @(negedge clk);
        check_output("raw delay 8 samples", $signed(g_cfg[1].bus.i_raw_delay_o), sent[sent.size() - 8]);
      end
    end

    // Back-to-back strobes.
    for (int j = 0; j < 10; j++)
      apply_stimulus(1'b1, 1'b1, $urandom, $urandom, j[1], 1'b0);

    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) begin
        apply_stimulus(1'b1, 1'b1, $urandom, $urandom, 1'b1, 1'b0);
        apply_stimulus(1'b1, 1'b0, $urandom, $urandom, 1'b1, 1'b0);
        reset_n = 1'b0;
        apply_stimulus(1'b1, 1'b1, $urandom, $urandom, 1'b1, 1'b0);
        apply_stimulus(1'b1, 1'b1, $urandom, $urandom, 1'b1, 1'b0);
        reset_n = 1'b1;
        @(negedge clk);
        check_output("mid reset ready_o", g_cfg[0].bus.ready_o, 0);
        check_output("mid reset e_out_o", g_cfg[1].bus.e_out_o, 0);
      end
      apply_stimulus(($urandom % 4) != 0, ($urandom % 3) == 0, $urandom, $urandom,
                     $urandom % 2, ($urandom % 200) == 0);
    end

    idle(PL + 6);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
